// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared types and constants for the truth-table sweeper
package sweep_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam int N_IN_DEF = 3;
    localparam int N_VEC    = 2**N_IN_DEF;
    localparam int HOLD_W   = 8;
endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// rtl/truth_table_sweeper_hold_timer.sv - counts HOLD cycles per vector, flags the last one
module hold_timer
    import sweep_pkg::*;
#(
    parameter int HOLD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD - 1);

    logic [HOLD_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= expire ? '0 : cnt + HOLD_W'(1);
        end
    end

    // expire is asserted during the last hold cycle, so the capture edge ends it
    assign expire = (cnt == LAST);
endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - walks all input vectors and captures the truth table of f_in
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int HOLD = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 f_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 tbl_valid,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        ones_cnt
);
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    state_t state, state_nx;
    logic   expire;
    logic   capture;
    logic   last_vec;

    hold_timer #(.HOLD(HOLD)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != RUN),
        .en     (state == RUN),
        .expire (expire)
    );

    assign capture  = (state == RUN) && expire;
    assign last_vec = (vec_out == LAST_VEC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (capture && last_vec) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        done = (state == FIN);
    end

    // vec_out stays at all-ones after a sweep; it is only cleared by the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out   <= '0;
            busy      <= 1'b0;
            tbl_valid <= 1'b0;
            table_out <= '0;
            ones_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_out   <= '0;
                        busy      <= 1'b1;
                        tbl_valid <= 1'b0;
                        table_out <= '0;
                        ones_cnt  <= '0;
                    end
                end
                RUN: begin
                    if (capture) begin
                        table_out[vec_out] <= f_in;
                        ones_cnt           <= ones_cnt + {{N_IN{1'b0}}, f_in};
                        if (last_vec) begin
                            busy      <= 1'b0;
                            tbl_valid <= 1'b1;
                        end else begin
                            vec_out <= vec_out + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - table-driven and random checks of truth_table_sweeper
module tb_truth_table_sweeper;
    localparam int HOLD = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start1;
    logic       f_in, f_in1;
    logic [2:0] vec_out, vec1;
    logic       busy, done, tbl_valid;
    logic       busy1, done1, tbl_valid1;
    logic [7:0] table_out, table1;
    logic [3:0] ones_cnt, ones1;

    int         checks = 0;
    int         failures = 0;
    int         mode = 2;
    logic [7:0] rtab = 8'h00;
    int         age = 0;

    typedef struct {
        int         mode;
        logic [7:0] tbl;
        int         ones;
        bit         repulse;
        string      name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(3), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .f_in(f_in), .vec_out(vec_out),
        .busy(busy), .done(done), .tbl_valid(tbl_valid), .table_out(table_out),
        .ones_cnt(ones_cnt)
    );

    truth_table_sweeper #(.N_IN(3), .HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .f_in(f_in1), .vec_out(vec1),
        .busy(busy1), .done(done1), .tbl_valid(tbl_valid1), .table_out(table1),
        .ones_cnt(ones1)
    );

    // Cycles elapsed within the current vector's hold window, used for the glitch stimulus
    always @(posedge clk) begin
        if (!busy || age == HOLD - 1) age <= 0;
        else age <= age + 1;
    end

    function automatic logic fmodel(input int m, input logic [2:0] v, input logic [7:0] r,
                                    input int a);
        logic fa, fb, fc;
        fa = v[2]; fb = v[1]; fc = v[0];
        case (m)
            0: return (fa & fb) | (fa & fc) | (fb & fc);
            1: return fa ^ fb ^ fc;
            2: return 1'b0;
            3: return 1'b1;
            4: return (a != HOLD - 1);
            default: return r[v];
        endcase
    endfunction

    always_comb f_in  = fmodel(mode, vec_out, rtab, age);
    always_comb f_in1 = vec1[2] & ~vec1[0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic sweep(input vec_t v);
        int bc = 0;
        int dc = 0;
        int first_b = -1;
        int done_at = -1;
        bit got = 0;
        mode = v.mode;
        rtab = v.tbl;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({v.name, " tbl_valid_cleared"}, tbl_valid, 0);
        for (int t = 0; t < 200 && !got; t++) begin
            if (t > 0) @(negedge clk);
            if (busy) begin
                bc++;
                if (first_b < 0) first_b = t;
            end
            if (done) begin
                dc++;
                got = 1;
                done_at = t;
                chk({v.name, " tbl_valid_at_done"}, tbl_valid, 1);
            end
            start = (v.repulse && (t == 15 || t == 45));
        end
        start = 1'b0;
        chk({v.name, " done_seen"}, got, 1);
        chk({v.name, " table"}, table_out, v.tbl);
        chk({v.name, " ones"}, ones_cnt, v.ones);
        chk({v.name, " busy_cycles"}, bc, 8 * HOLD);
        chk({v.name, " done_offset"}, done_at - first_b, 8 * HOLD);
        @(negedge clk);
        chk({v.name, " done_one_cycle"}, done, 0);
        chk({v.name, " tbl_valid_held"}, tbl_valid, 1);
        chk({v.name, " vec_hold"}, vec_out, 3'd7);
    endtask

    initial begin
        vec_t v;
        int   dcount;
        bit   bad;
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset tbl_valid", tbl_valid, 0);
        chk("reset table", table_out, 0);
        chk("reset ones", ones_cnt, 0);
        chk("reset vec", vec_out, 0);
        rst = 1'b0;
        @(negedge clk);

        vecs.push_back('{0, 8'hE8, 4, 0, "majority"});
        vecs.push_back('{1, 8'h96, 4, 0, "xor3"});
        vecs.push_back('{2, 8'h00, 0, 0, "tied0"});
        vecs.push_back('{3, 8'hFF, 8, 0, "tied1"});
        vecs.push_back('{0, 8'hE8, 4, 1, "repulse"});
        vecs.push_back('{4, 8'h00, 0, 0, "glitch"});
        for (int i = 0; i < 4; i++) begin
            v.mode = 5;
            v.tbl = 8'($urandom);
            v.ones = $countones(v.tbl);
            v.repulse = 0;
            v.name = "random";
            vecs.push_back(v);
        end
        foreach (vecs[i]) sweep(vecs[i]);

        // Reset while vec_out == 4 aborts the sweep with no done pulse
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int t = 0; t < 200 && vec_out != 3'd4; t++) @(negedge clk);
        chk("abort reached_vec4", vec_out, 3'd4);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort vec", vec_out, 0);
        chk("abort table", table_out, 0);
        chk("abort ones", ones_cnt, 0);
        chk("abort tbl_valid", tbl_valid, 0);
        dcount = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("abort no_activity", dcount, 0);
        sweep('{0, 8'hE8, 4, 0, "after_abort"});

        // start held high restarts on the edge after FIN
        mode = 1;
        start = 1'b1;
        dcount = 0;
        for (int t = 0; t < 170; t++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        start = 1'b0;
        chk("held_start done_count", dcount, 2);
        for (int t = 0; t < 200 && (busy || done); t++) @(negedge clk);
        chk("held_start idle", busy, 0);
        chk("held_start table", table_out, 8'h96);

        // HOLD=1: one vector per cycle
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        dcount = 0;
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            if (t > 0) @(negedge clk);
            if (busy1) begin
                if (vec1 != 3'(dcount)) bad = 1;
                dcount++;
            end
            if (done1) break;
        end
        chk("hold1 done", done1, 1);
        chk("hold1 busy_cycles", dcount, 8);
        chk("hold1 vec_step", bad, 0);
        chk("hold1 table", table1, 8'h50);
        chk("hold1 ones", ones1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
